// File: rtl/mcycle_unit.sv
// Iterative 32x32 multiply/divide unit for the EX stage; Busy drives the pipeline stall.
// Optional build macro MCYCLE_EARLY_TERM_EN: multiply exits once the remaining multiplier bits are zero.
module mcycle_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTING, S_DONE} state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_op;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_op1;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_result1;
    logic [WIDTH-1:0]   r_result2;

    logic               w_signed, w_op1_neg, w_op2_neg;
    logic [WIDTH-1:0]   w_abs1, w_abs2;
    logic               w_is_mul, w_last;
    logic [ACC_W-1:0]   w_mul_acc, w_div_acc, w_step_acc, w_prod;
    logic [WIDTH:0]     w_top;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem, w_quo_u, w_rem_u;
    logic [WIDTH-1:0]   w_res1, w_res2;
    logic               w_unused;

    assign Result1 = r_result1;
    assign Result2 = r_result2;

    // Operand conditioning at acceptance: magnitudes for signed ops
    assign w_signed  = ~MCycleOp[0];
    assign w_op1_neg = w_signed & Operand1[WIDTH-1];
    assign w_op2_neg = w_signed & Operand2[WIDTH-1];
    assign w_abs1    = w_op1_neg ? (~Operand1 + WIDTH'(1)) : Operand1;
    assign w_abs2    = w_op2_neg ? (~Operand2 + WIDTH'(1)) : Operand2;

    assign w_is_mul  = ~r_op[1];
    assign w_mul_acc = r_acc + (r_b[0] ? r_mcand : ACC_W'(0));

    // Restoring divide step; partial remainder needs one extra bit after the shift
    assign w_top     = r_acc[ACC_W-1:WIDTH-1];
    assign w_diff    = {1'b0, w_top} - {2'b00, r_b};
    assign w_qbit    = ~w_diff[WIDTH+1];
    assign w_rem     = w_qbit ? w_diff[WIDTH-1:0] : w_top[WIDTH-1:0];
    assign w_div_acc = {w_rem, r_acc[WIDTH-2:0], w_qbit};
    assign w_unused  = w_diff[WIDTH];

    assign w_step_acc = w_is_mul ? w_mul_acc : w_div_acc;

`ifdef MCYCLE_EARLY_TERM_EN
    assign w_last = (r_count == CNT_W'(WIDTH - 1)) || (w_is_mul && ((r_b >> 1) == WIDTH'(0)));
`else
    assign w_last = (r_count == CNT_W'(WIDTH - 1));
`endif

    // Sign correction and special cases applied on the final iteration
    assign w_prod  = r_neg_q ? (~w_mul_acc + ACC_W'(1)) : w_mul_acc;
    assign w_quo_u = w_div_acc[WIDTH-1:0];
    assign w_rem_u = w_div_acc[ACC_W-1:WIDTH];

    always_comb begin
        w_res1 = w_prod[WIDTH-1:0];
        w_res2 = w_prod[ACC_W-1:WIDTH];
        if (!w_is_mul) begin
            if (r_b == WIDTH'(0)) begin
                w_res1 = {WIDTH{1'b1}};
                w_res2 = r_op1;
            end else begin
                w_res1 = r_neg_q ? (~w_quo_u + WIDTH'(1)) : w_quo_u;
                w_res2 = r_neg_r ? (~w_rem_u + WIDTH'(1)) : w_rem_u;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        Busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                Busy = Start;
                if (Start) w_state_next = S_COMPUTING;
            end
            S_COMPUTING: begin
                Busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (Reset) Busy = 1'b0;
    end

    // Datapath: latch on accept, one iteration per COMPUTING cycle, results only at completion
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_count   <= '0;
            r_op      <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_b       <= '0;
            r_op1     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result1 <= '0;
            r_result2 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_op    <= MCycleOp;
                        r_acc   <= MCycleOp[1] ? {WIDTH'(0), w_abs1} : ACC_W'(0);
                        r_mcand <= {WIDTH'(0), w_abs1};
                        r_b     <= w_abs2;
                        r_op1   <= Operand1;
                        r_neg_q <= w_op1_neg ^ w_op2_neg;
                        r_neg_r <= w_op1_neg;
                        r_count <= '0;
                    end
                end
                S_COMPUTING: begin
                    r_acc   <= w_step_acc;
                    r_mcand <= r_mcand << 1;
                    r_count <= r_count + CNT_W'(1);
                    if (w_is_mul) r_b <= r_b >> 1;
                    if (w_last) begin
                        r_result1 <= w_res1;
                        r_result2 <= w_res2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed cases plus randomized ops against an arithmetic model.
module tb_mcycle_unit;

    localparam int unsigned WIDTH = 32;

    logic             CLK;
    logic             Reset;
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;

    int n_tests = 0;
    int n_fail  = 0;

    mcycle_unit #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result {Result2, Result1} from plain arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb, q, r;
        case (op)
            2'b00: begin
                sa = int'(a); sb = int'(b);
                sp = longint'(sa) * longint'(sb);
                return 64'(sp);
            end
            2'b01: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                return 64'(up);
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = int'(a); sb = int'(b);
                q = sa / sb; r = sa % sb;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
        int msb;
        logic [31:0] mag;
        msb = -1;
        mag = (op == 2'b00 && b[31]) ? (~b + 32'd1) : b;
        for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
`ifdef MCYCLE_EARLY_TERM_EN
        if (!op[1]) return (msb < 0) ? 2 : msb + 2;
`endif
        return WIDTH + 1;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int lat, guard;
        exp = model(op, a, b);
        @(negedge CLK);
        MCycleOp = op; Operand1 = a; Operand2 = b; Start = 1'b1;
        #1;
        lat = 0; guard = 0;
        while (Busy && guard < 200) begin
            lat++;
            @(negedge CLK);
            MCycleOp = 2'($urandom); Operand1 = $urandom; Operand2 = $urandom;
            #1;
            guard++;
        end
        check({tag, "_busy_cycles"}, 64'(lat), 64'(exp_latency(op, b)));
        check({tag, "_result"}, {Result2, Result1}, exp);
        @(negedge CLK);
        Start = 1'b0;
        #1;
        check({tag, "_no_retrigger"}, 64'(Busy), 64'd0);
        check({tag, "_held"}, {Result2, Result1}, exp);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        int sel;

        Reset = 1'b1; Start = 1'b1; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
        repeat (2) @(negedge CLK);
        #1;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_results", {Result2, Result1}, 64'd0);
        Start = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;

        run_op("umul_ffff", 2'b01, 32'h0000_FFFF, 32'h0001_0001);
        run_op("smul_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7);
        run_op("umul_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("sdiv_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("udiv_100d7", 2'b11, 32'd100, 32'd7);
        run_op("udiv_zero", 2'b11, 32'h1234_5678, 32'd0);
        run_op("sdiv_zero", 2'b10, 32'hFFFF_FF00, 32'd0);
        run_op("sdiv_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("umul_5x3", 2'b01, 32'd5, 32'd3);
        run_op("smul_x0", 2'b00, 32'h1234_5678, 32'd0);

        // Asynchronous reset in the middle of an operation
        @(negedge CLK);
        MCycleOp = 2'b01; Operand1 = 32'h0000_FFFF; Operand2 = 32'h0001_0001; Start = 1'b1;
        repeat (11) @(negedge CLK);
        Reset = 1'b1;
        #1;
        check("midop_reset_busy", 64'(Busy), 64'd0);
        check("midop_reset_results", {Result2, Result1}, 64'd0);
        @(negedge CLK);
        Reset = 1'b0; Start = 1'b0;
        run_op("after_reset", 2'b10, 32'hFFFF_FF9C, 32'd7);

        for (int i = 0; i < 30; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(0, 20));
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
